// File: rtl/clahe_pkg.sv
// clahe_pkg: shared widths, tile geometry and counter width helpers for the CLAHE coordinate path
package clahe_pkg;
  localparam int TILE_LOG2 = 6;
  localparam int WEIGHT_W = 6;
  localparam int PIX_W = 8;
  localparam int LANES = 3;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int tile_w(input int n);
    return cnt_w((n + 63) / 64);
  endfunction
endpackage

// File: rtl/clahe_raster_cnt.sv
// clahe_raster_cnt: column/row raster counters with wrap, sof restart and eol/eof/sync-error detection
// Ports: clk, rst_n (async active-low), clk_en, i_valid, i_sof in; o_col/o_row give the position used
// by the current pixel (0,0 on sof), o_eol/o_eof/o_sync_err flag that pixel combinationally.
module clahe_raster_cnt
  import clahe_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int CW = cnt_w(IMG_W),
  localparam int RW = cnt_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          i_valid,
  input  logic          i_sof,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_sync_err
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;
  always_comb begin
    accept = i_valid && clk_en;
    o_col = i_sof ? '0 : col_q;
    o_row = i_sof ? '0 : row_q;
    o_eol = o_col == CW'(IMG_W - 1);
    o_eof = o_eol && (o_row == RW'(IMG_H - 1));
    o_sync_err = i_valid && i_sof && ((col_q != '0) || (row_q != '0));
    col_d = !accept ? col_q : o_eol ? '0 : o_col + CW'(1);
    row_d = !accept ? row_q : !o_eol ? o_row : o_eof ? '0 : o_row + RW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
endmodule

// File: rtl/clahe_coord_gen.sv
// clahe_coord_gen: per-pixel horizontal/vertical weights, tile indices and raster markers for the CLAHE multiplier
// Ports: clk, rst_n (async active-low), clk_en stall, i_valid/i_sof/i_pixel in; o_weight (multiplier dataa,
// replicated per lane), o_pixel (datab), o_wy, o_tile_x/y, o_valid, o_sof, o_eol, o_eof, o_sync_err out.
module clahe_coord_gen
  import clahe_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int TILE_LOG2 = 6,
  localparam int TX_W = tile_w(IMG_W),
  localparam int TY_W = tile_w(IMG_H),
  localparam int CW = cnt_w(IMG_W),
  localparam int RW = cnt_w(IMG_H)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clk_en,
  input  logic                            i_valid,
  input  logic                            i_sof,
  input  logic [LANES-1:0][PIX_W-1:0]     i_pixel,
  output logic [LANES-1:0][WEIGHT_W-1:0]  o_weight,
  output logic [LANES-1:0][PIX_W-1:0]     o_pixel,
  output logic [WEIGHT_W-1:0]             o_wy,
  output logic [TX_W-1:0]                 o_tile_x,
  output logic [TY_W-1:0]                 o_tile_y,
  output logic                            o_valid,
  output logic                            o_sof,
  output logic                            o_eol,
  output logic                            o_eof,
  output logic                            o_sync_err
);
  if (TILE_LOG2 != 6) begin : g_bad_tile
    $error("clahe_coord_gen: TILE_LOG2 must be 6 so weights fit 6 bits");
  end
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol, eof, sync_err, accept;
  logic [LANES-1:0][WEIGHT_W-1:0] weight_q, weight_d;
  logic [LANES-1:0][PIX_W-1:0]    pixel_q, pixel_d;
  logic [WEIGHT_W-1:0]            wy_q, wy_d;
  logic [TX_W-1:0]                tile_x_q, tile_x_d;
  logic [TY_W-1:0]                tile_y_q, tile_y_d;
  logic valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, err_q, err_d;
  clahe_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .o_col      (col),
    .o_row      (row),
    .o_eol      (eol),
    .o_eof      (eof),
    .o_sync_err (sync_err)
  );
  // Flags are strobes tied to o_valid; data outputs hold across idle cycles.
  always_comb begin
    accept = i_valid && clk_en;
    valid_d = clk_en ? i_valid : valid_q;
    sof_d = clk_en ? i_valid && i_sof : sof_q;
    eol_d = clk_en ? i_valid && eol : eol_q;
    eof_d = clk_en ? i_valid && eof : eof_q;
    err_d = clk_en ? sync_err : err_q;
    weight_d = accept ? {LANES{WEIGHT_W'(col)}} : weight_q;
    pixel_d = accept ? i_pixel : pixel_q;
    wy_d = accept ? WEIGHT_W'(row) : wy_q;
    tile_x_d = accept ? TX_W'(col >> TILE_LOG2) : tile_x_q;
    tile_y_d = accept ? TY_W'(row >> TILE_LOG2) : tile_y_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      weight_q <= '0;
      pixel_q  <= '0;
      wy_q     <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
    end else begin
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      weight_q <= weight_d;
      pixel_q  <= pixel_d;
      wy_q     <= wy_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
    end
  assign o_valid    = valid_q;
  assign o_sof      = sof_q;
  assign o_eol      = eol_q;
  assign o_eof      = eof_q;
  assign o_sync_err = err_q;
  assign o_weight   = weight_q;
  assign o_pixel    = pixel_q;
  assign o_wy       = wy_q;
  assign o_tile_x   = tile_x_q;
  assign o_tile_y   = tile_y_q;
endmodule

// File: tb/tb_clahe_coord_gen.sv
// tb_clahe_coord_gen: scoreboard bench for clahe_coord_gen on a 130x3 image
module tb_clahe_coord_gen;
  localparam int W = 130;
  localparam int H = 3;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, i_valid = 1'b0, i_sof = 1'b0;
  logic [2:0][7:0] i_pixel = '0;
  logic [2:0][5:0] o_weight;
  logic [2:0][7:0] o_pixel;
  logic [5:0] o_wy;
  logic [1:0] o_tile_x;
  logic       o_tile_y;
  logic o_valid, o_sof, o_eol, o_eof, o_sync_err;
  int n_tests = 0, n_fail = 0, n_valid = 0, n_accept = 0;
  int mc = 0, mr = 0;
  logic [56:0] exp_last = '0;
  logic [56:0] sb[$];
  always #5 clk = ~clk;
  clahe_coord_gen #(.IMG_W(W), .IMG_H(H), .TILE_LOG2(6)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_valid(i_valid), .i_sof(i_sof),
    .i_pixel(i_pixel), .o_weight(o_weight), .o_pixel(o_pixel), .o_wy(o_wy),
    .o_tile_x(o_tile_x), .o_tile_y(o_tile_y), .o_valid(o_valid), .o_sof(o_sof),
    .o_eol(o_eol), .o_eof(o_eof), .o_sync_err(o_sync_err)
  );
  function automatic logic [56:0] dut_vec();
    return {o_valid, o_sof, o_eol, o_eof, o_sync_err, o_weight, o_pixel, o_wy,
            o_tile_x, 1'b0, o_tile_y};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle(input string tag, input logic v, input logic s, input logic e,
                       input logic [23:0] pix);
    logic [56:0] exp;
    int uc, ur;
    logic eol, eof, err;
    @(negedge clk);
    i_valid = v;
    i_sof = s;
    clk_en = e;
    i_pixel = pix;
    if (v && e) begin
      err = s && (mc != 0 || mr != 0);
      uc = s ? 0 : mc;
      ur = s ? 0 : mr;
      eol = uc == W - 1;
      eof = eol && ur == H - 1;
      sb.push_back({1'b1, s, eol, eof, err, {3{6'(uc % 64)}}, pix, 6'(ur % 64),
                    2'(uc / 64), 2'(ur / 64)});
      mc = eol ? 0 : uc + 1;
      mr = eol ? (ur == H - 1 ? 0 : ur + 1) : ur;
      n_accept++;
    end
    @(posedge clk);
    #1;
    if (!e) exp = exp_last;
    else if (v) begin
      chk({tag, "_sbdepth"}, 64'(sb.size()), 64'd1);
      exp = (sb.size() != 0) ? sb.pop_front() : exp_last;
    end else exp = {5'b0, exp_last[51:0]};
    chk(tag, 64'(dut_vec()), 64'(exp));
    if (e && o_valid) n_valid++;
    exp_last = exp;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 64'(dut_vec()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 390; i++) begin
      if (i == 11) repeat (3) cycle("stall", 1'b1, 1'b0, 1'b0, 24'($urandom));
      if (i == 20) cycle("sof_noval", 1'b0, 1'b1, 1'b1, 24'($urandom));
      if (i == 140) cycle("gap", 1'b0, 1'b0, 1'b1, 24'($urandom));
      cycle(i == 63 ? "col63" : i == 65 ? "col65" : i == 129 ? "eol" : i == 389 ? "eof" : "px",
            1'b1, i == 0, 1'b1, i == 63 ? 24'hFF8001 : 24'($urandom));
    end
    cycle("wrap", 1'b1, 1'b0, 1'b1, 24'($urandom));
    for (int i = 0; i < 129 + 50; i++) cycle("px2", 1'b1, 1'b0, 1'b1, 24'($urandom));
    cycle("midsof", 1'b1, 1'b1, 1'b1, 24'($urandom));
    cycle("after_sof", 1'b1, 1'b0, 1'b1, 24'($urandom));
    for (int i = 0; i < 68; i++) cycle("px3", 1'b1, 1'b0, 1'b1, 24'($urandom));
    @(negedge clk);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(dut_vec()), 64'd0);
    mc = 0;
    mr = 0;
    exp_last = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 1'b0, 1'b1, 24'h123456);
    cycle("idle", 1'b0, 1'b0, 1'b1, 24'h0);
    chk("vcount", 64'(n_valid), 64'(n_accept));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
